uart_print_arb: RTL and testbench

Round-robin arbiter that shares the single print path of `uart_tx_ctrl` among `NUM_REQ` print requesters, such as per-hart MMIO print ports and a debug tracer. It buffers each requester's 32-bit words in a private 2-entry slot and issues one word per cycle on `print_en`/`print_data`. It never issues a word in a cycle where the TX FIFO is full or a protocol response (ACK/NAK) is being enqueued, so no print word is ever dropped downstream.

---
 rtl/uart_print_arb_pkg.sv | 14 +
 rtl/uart_print_arb_if.sv | 20 ++
 rtl/uart_print_slot.sv | 42 ++++
 rtl/uart_print_arb.sv | 70 +++++++
 tb/tb_uart_print_arb.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/uart_print_arb_pkg.sv
// Shared UART definitions: response codes seen by uart_tx_ctrl and print arbiter sizing.
package uart_defines;
    typedef enum logic [2:0] {
        RES_NONE = 3'd0,
        RES_OK   = 3'd1,
        RES_ACK  = 3'd2,
        RES_NAK  = 3'd3,
        RES_BUSY = 3'd4
    } uart_res_t;

    localparam int PRINT_ARB_REQ    = 4;
    localparam int PRINT_SLOT_DEPTH = 2;
    localparam int PRINT_W          = 32;
endpackage

// File: rtl/uart_print_arb_if.sv
// Requester/print bundle between the print requesters, uart_print_arb and uart_tx_ctrl.
interface uart_print_arb_if #(parameter int NUM_REQ = uart_defines::PRINT_ARB_REQ);
    import uart_defines::*;
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0][PRINT_W-1:0] req_data;
    logic [NUM_REQ-1:0]              req_ready;
    uart_res_t                       res;
    logic                            tx_fifo_full;
    logic                            print_en;
    logic [PRINT_W-1:0]              print_data;
    logic [GW-1:0]                   grant_id;
    logic                            pending;

    modport master (output req_valid, req_data, res, tx_fifo_full,
                    input  req_ready, print_en, print_data, grant_id, pending);
    modport slave  (input  req_valid, req_data, res, tx_fifo_full,
                    output req_ready, print_en, print_data, grant_id, pending);
endinterface

// File: rtl/uart_print_slot.sv
// Two-entry per-requester FIFO; pointers carry a wrap bit so full/empty fall out of compare.
module uart_print_slot
    import uart_defines::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [PRINT_W-1:0] data_i,
    output logic [PRINT_W-1:0] head_o,
    output logic [1:0]         count_o,
    output logic               ready_o
);
    logic [1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [PRINT_W-1:0] mem_q [PRINT_SLOT_DEPTH];
    logic               full, empty, do_push, do_pop;

    assign full    = (wr_q[1] != rd_q[1]) && (wr_q[0] == rd_q[0]);
    assign empty   = (wr_q == rd_q);
    assign count_o = wr_q - rd_q;
    assign ready_o = !full;
    assign head_o  = mem_q[rd_q[0]];
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;
    assign wr_d    = wr_q + {1'b0, do_push};
    assign rd_d    = rd_q + {1'b0, do_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= 2'd0;
            rd_q <= 2'd0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_q[0]] <= data_i;
    end
endmodule

// File: rtl/uart_print_arb.sv
// Round-robin arbiter sharing the uart_tx_ctrl print path; never issues while ACK/NAK or FIFO full.
module uart_print_arb
    import uart_defines::*;
#(
    parameter int NUM_REQ = PRINT_ARB_REQ
) (
    input  logic            clk,
    input  logic            rst,
    uart_print_arb_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]  elig, pop, ready;
    logic [PRINT_W-1:0]  head [NUM_REQ];
    logic [1:0]          cnt  [NUM_REQ];
    logic [GW-1:0]       rr_q, rr_d, sel;
    logic                found, blocked, grant;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        uart_print_slot u_slot (
            .clk    (clk),
            .rst    (rst),
            .push_i (bus.req_valid[i]),
            .pop_i  (pop[i]),
            .data_i (bus.req_data[i]),
            .head_o (head[i]),
            .count_o(cnt[i]),
            .ready_o(ready[i])
        );
        assign elig[i] = (cnt[i] != 2'd0);
    end

    assign bus.req_ready = ready;
    assign blocked = rst || bus.tx_fifo_full || (bus.res == RES_ACK) || (bus.res == RES_NAK);

    // First eligible slot scanning upward from rr_ptr with wraparound.
    always_comb begin : p_scan
        logic [GW:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_q} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
            if (!found && elig[idx[GW-1:0]]) begin
                found = 1'b1;
                sel   = idx[GW-1:0];
            end
        end
    end

    assign grant = !blocked && found;

    always_comb begin
        pop      = '0;
        pop[sel] = grant;
    end

    assign bus.print_en   = grant;
    assign bus.print_data = grant ? head[sel] : '0;
    assign bus.grant_id   = grant ? sel : '0;
    assign bus.pending    = !rst && (|elig);

    assign rr_d = !grant ? rr_q : (sel == GW'(NUM_REQ-1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end
endmodule

// File: tb/tb_uart_print_arb.sv
// Directed plus random stimulus checked against a queue-per-requester round-robin model.
module tb_uart_print_arb;
    import uart_defines::*;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_print_arb_if #(.NUM_REQ(N)) bus();
    uart_print_arb #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, failures = 0;
    logic [31:0] q [N][$];
    int          rr = 0;

    logic        o_en, o_pend;
    logic [31:0] o_data;
    logic [1:0]  o_gid;
    logic [N-1:0] o_ready;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        int g, idx;
        logic blk, any;
        logic [N-1:0] acc;
        logic [N-1:0][31:0] din;
        #1;
        blk = rst || bus.tx_fifo_full || bus.res == RES_ACK || bus.res == RES_NAK;
        g = -1;
        any = 1'b0;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) any = 1'b1;
        if (!blk)
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && q[idx].size() > 0) g = idx;
            end
        o_en = bus.print_en; o_data = bus.print_data; o_gid = bus.grant_id;
        o_pend = bus.pending; o_ready = bus.req_ready;
        chk("print_en", 32'(o_en), 32'(g >= 0));
        chk("print_data", o_data, (g >= 0) ? q[(g < 0) ? 0 : g][0] : 32'h0);
        chk("grant_id", 32'(o_gid), (g >= 0) ? 32'(g) : 32'h0);
        chk("pending", 32'(o_pend), 32'(!rst && any));
        if (!rst)
            for (int i = 0; i < N; i++)
                chk($sformatf("req_ready%0d", i), 32'(o_ready[i]), 32'(q[i].size() != 2));
        for (int i = 0; i < N; i++) acc[i] = bus.req_valid[i] && (q[i].size() < 2);
        din = bus.req_data;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            rr = 0;
        end else begin
            if (g >= 0) begin
                void'(q[g].pop_front());
                rr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) if (acc[i]) q[i].push_back(din[i]);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.res = RES_NONE;
        bus.tx_fifo_full = 1'b0;
        repeat (2) cycle();
        chk("rst_print_en", 32'(o_en), 32'h0);
        chk("rst_pending", 32'(o_pend), 32'h0);
        rst = 1'b0;
        cycle();
        chk("post_rst_ready", 32'(o_ready), 32'hF);

        // Single word on requester 2
        bus.req_valid[2] = 1'b1; bus.req_data[2] = 32'hDEADBEEF;
        cycle();
        bus.req_valid = '0;
        cycle();
        chk("t1_en", 32'(o_en), 32'h1);
        chk("t1_data", o_data, 32'hDEADBEEF);
        chk("t1_gid", 32'(o_gid), 32'h2);
        cycle();
        chk("t1_pending", 32'(o_pend), 32'h0);

        // Round-robin from a fresh rr_ptr
        rst = 1'b1; cycle(); rst = 1'b0;
        bus.tx_fifo_full = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) bus.req_data[i] = 32'h1000 + i;
        cycle();
        bus.req_valid = '0; bus.tx_fifo_full = 1'b0;
        for (int k = 0; k < N; k++) begin
            cycle();
            chk("rr_gid", 32'(o_gid), 32'(k));
            chk("rr_data", o_data, 32'h1000 + k);
        end
        bus.tx_fifo_full = 1'b1; bus.req_valid = 4'b1010;
        cycle();
        bus.req_valid = '0; bus.tx_fifo_full = 1'b0;
        cycle(); chk("rr13_a", 32'(o_gid), 32'h1);
        cycle(); chk("rr13_b", 32'(o_gid), 32'h3);

        // ACK collision holds the word
        bus.res = RES_ACK; bus.req_valid[0] = 1'b1; bus.req_data[0] = 32'hA0;
        cycle();
        bus.req_valid = '0;
        repeat (2) begin cycle(); chk("ack_en", 32'(o_en), 32'h0); end
        bus.res = RES_OK;
        cycle();
        chk("ack_rel_en", 32'(o_en), 32'h1);
        chk("ack_rel_data", o_data, 32'hA0);

        // Backpressure: third word held by the requester
        bus.tx_fifo_full = 1'b1; bus.req_valid[1] = 1'b1;
        bus.req_data[1] = 32'hB0; cycle();
        bus.req_data[1] = 32'hB1; cycle();
        bus.req_data[1] = 32'hB2; cycle();
        chk("bp_ready", 32'(o_ready[1]), 32'h0);
        bus.tx_fifo_full = 1'b0;
        cycle(); chk("bp_w0", o_data, 32'hB0);
        cycle(); chk("bp_w1", o_data, 32'hB1);
        bus.req_valid = '0;
        cycle(); chk("bp_w2", o_data, 32'hB2);

        // Push and pop on the same slot in one cycle
        bus.tx_fifo_full = 1'b1; bus.req_valid[0] = 1'b1; bus.req_data[0] = 32'hC0;
        cycle();
        bus.tx_fifo_full = 1'b0; bus.req_data[0] = 32'hC1;
        cycle(); chk("pp_old", o_data, 32'hC0);
        bus.req_valid = '0;
        cycle(); chk("pp_new", o_data, 32'hC1);
        cycle(); chk("pp_empty", 32'(o_pend), 32'h0);

        // Mid-burst reset discards buffered words
        bus.tx_fifo_full = 1'b1; bus.req_valid = 4'b0111;
        cycle();
        bus.req_valid = '0; bus.tx_fifo_full = 1'b0; rst = 1'b1;
        cycle(); chk("mr_en", 32'(o_en), 32'h0);
        rst = 1'b0;
        cycle(); chk("mr_pending", 32'(o_pend), 32'h0);
        bus.tx_fifo_full = 1'b1; bus.req_valid = '1;
        cycle();
        bus.req_valid = '0; bus.tx_fifo_full = 1'b0;
        cycle(); chk("mr_first_gid", 32'(o_gid), 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.req_valid = N'($urandom);
            for (int i = 0; i < N; i++) bus.req_data[i] = $urandom;
            bus.tx_fifo_full = ($urandom_range(0, 3) == 0);
            bus.res = uart_res_t'($urandom_range(0, 4));
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
